// File: rtl/io_stimulus_gen.sv
// Stimulus source for sc_computer_main I/O: delayed DUT reset release, patterned switches, round-robin keys.
// Every output is registered and updates on the clock edge after its decision; there is no backpressure, only enable/step gating.
module io_stimulus_gen #(
  parameter int                  SW_WIDTH   = 10,
  parameter int                  KEY_WIDTH  = 4,
  parameter int                  RESET_HOLD = 5,
  parameter int                  SW_PERIOD  = 20,
  parameter int                  KEY_PERIOD = 64,
  parameter int                  KEY_PULSE  = 4,
  parameter logic [SW_WIDTH-1:0] SW_INIT    = 10'h2AA,
  parameter logic [SW_WIDTH-1:0] LFSR_TAPS  = 10'h240
) (
  input  logic                 clock_50M,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic                 step,
  output logic                 dut_resetn,
  output logic [SW_WIDTH-1:0]  sw,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 sw_strobe,
  output logic [31:0]          cycle_count
);

  localparam int HW  = $clog2(RESET_HOLD + 1);
  localparam int SPW = $clog2(SW_PERIOD + 1);
  localparam int KPW = $clog2(KEY_PERIOD + 1);
  localparam int PLW = $clog2(KEY_PULSE + 1);
  localparam int IW  = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;

  typedef enum logic [1:0] {HOLD, RUN, PAUSE} state_t;

  state_t              state, state_nxt;
  logic [HW-1:0]       hold_cnt;
  logic [SPW-1:0]      sw_cnt;
  logic [KPW-1:0]      kp_cnt;
  logic [PLW-1:0]      pls_cnt;
  logic [IW-1:0]       key_idx;
  logic                sw_upd;
  logic [SW_WIDTH-1:0] sw_nxt;

  always_ff @(posedge clock_50M or negedge resetn) begin
    if (!resetn) state <= HOLD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sw_upd    = 1'b0;
    case (state)
      HOLD: begin
        if (hold_cnt == HW'(RESET_HOLD - 1)) state_nxt = enable ? RUN : PAUSE;
      end
      RUN: begin
        sw_upd = (sw_cnt == SPW'(SW_PERIOD - 1));
        if (!enable) state_nxt = PAUSE;
      end
      PAUSE: begin
        sw_upd = step;
        if (enable) state_nxt = RUN;
      end
      default: state_nxt = HOLD;
    endcase
  end

  // Zero is a fixed point of both rotate and LFSR, so both escape to 1.
  always_comb begin
    sw_nxt = sw;
    case (mode)
      2'd0:    sw_nxt = ~sw;
      2'd1:    sw_nxt = sw + SW_WIDTH'(1);
      2'd2:    sw_nxt = (sw == '0) ? SW_WIDTH'(1) : {sw[SW_WIDTH-2:0], sw[SW_WIDTH-1]};
      default: sw_nxt = (sw == '0) ? SW_WIDTH'(1) : ((sw >> 1) ^ (sw[0] ? LFSR_TAPS : '0));
    endcase
  end

  always_ff @(posedge clock_50M or negedge resetn) begin
    if (!resetn) begin
      hold_cnt    <= '0;
      dut_resetn  <= 1'b0;
      sw          <= SW_INIT;
      sw_strobe   <= 1'b0;
      sw_cnt      <= '0;
      cycle_count <= '0;
      kp_cnt      <= '0;
      pls_cnt     <= '0;
      key_idx     <= '0;
      key         <= '1;
    end else begin
      dut_resetn <= (state_nxt != HOLD);
      sw_strobe  <= sw_upd;
      if (sw_upd) sw <= sw_nxt;
      if (state == HOLD) hold_cnt <= hold_cnt + HW'(1);
      if (state == RUN) begin
        sw_cnt <= sw_upd ? '0 : sw_cnt + SPW'(1);
        if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
        kp_cnt <= (kp_cnt == KPW'(KEY_PERIOD - 1)) ? '0 : kp_cnt + KPW'(1);
        // The key index advances when a pulse starts, so an aborted pulse still moves on.
        if (kp_cnt == '0) begin
          key     <= ~(KEY_WIDTH'(1) << key_idx);
          pls_cnt <= PLW'(1);
          key_idx <= (key_idx == IW'(KEY_WIDTH - 1)) ? '0 : key_idx + IW'(1);
        end else if (pls_cnt != '0) begin
          if (pls_cnt == PLW'(KEY_PULSE)) begin
            pls_cnt <= '0;
            key     <= '1;
          end else begin
            pls_cnt <= pls_cnt + PLW'(1);
          end
        end
      end
      if (state_nxt != RUN) begin
        key     <= '1;
        pls_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/io_stimulus_gen.md
Name: io_stimulus_gen

Overview:
Synthesisable, parametrised stimulus source for the single-cycle computer's I/O ports. Releases a held DUT reset after a programmable delay, then drives the switch bank with one of four selectable patterns at a programmable period, and sequences active-low key presses round-robin. It sits between the board clock/reset and the sc_computer_main sw/key/resetn inputs, for on-board self-test or as a bench driver. This replaces ad-hoc testbench waveforms.

Parameters:
SW_WIDTH, 10, switch bus width (>=2)
KEY_WIDTH, 4, key bus width (>=1)
RESET_HOLD, 5, cycles dut_resetn stays low after resetn release (>=1)
SW_PERIOD, 20, cycles between switch updates in RUN (>=1)
KEY_PERIOD, 64, cycles between key-press starts (> KEY_PULSE)
KEY_PULSE, 4, cycles a key is held low (>=1)
SW_INIT, 10'h2AA, switch value loaded at reset
LFSR_TAPS, 10'h240, Galois LFSR tap mask for mode 3

Ports:
clock_50M  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
enable  input  1  1 = run patterns, 0 = pause
mode  input  2  switch pattern: 0 toggle, 1 increment, 2 walking rotate, 3 LFSR
step  input  1  single-cycle pulse; forces one switch update while paused
dut_resetn  output  1  reset to DUT, active low
sw  output  SW_WIDTH  switch stimulus
key  output  KEY_WIDTH  key stimulus, active low
sw_strobe  output  1  1-cycle pulse coincident with each new sw value
cycle_count  output  32  RUN-state cycle count, saturating

Behaviour:
- Reset (resetn=0, async): state=HOLD, dut_resetn=0, sw=SW_INIT, key=all 1s, sw_strobe=0, cycle_count=0, period/pulse counters=0, key index=0.
- FSM states HOLD, RUN, PAUSE.
- HOLD: hold counter increments each cycle; dut_resetn=0. After RESET_HOLD cycles (counter reaches RESET_HOLD-1), next state RUN if enable=1, else PAUSE; dut_resetn=1 from the first cycle of that state onward. enable/step ignored in HOLD.
- RUN: sw period counter counts 0..SW_PERIOD-1. At terminal count: sw updates on the next edge, sw_strobe=1 for that one cycle, counter wraps to 0. cycle_count +1 per RUN cycle, saturates at 32'hFFFFFFFF.
- RUN -> PAUSE when enable=0 (sampled; takes effect next cycle). PAUSE -> RUN when enable=1. Counters resume from frozen values (no restart).
- PAUSE: sw, cycle_count, period counter frozen. key forced all 1s, key pulse counter cleared, key period counter frozen. step=1 -> sw updates next edge with sw_strobe=1; period counter unchanged. step in RUN ignored.
- Update rules (mode sampled at update edge; mid-period change affects next update only):
  0: sw <= ~sw.
  1: sw <= sw+1, modulo 2^SW_WIDTH (all 1s wraps to 0).
  2: sw <= rotate left by 1; if sw==0, sw <= 1.
  3: if sw==0, sw <= 1 (lock-up escape); else sw <= (sw>>1) ^ (sw[0] ? LFSR_TAPS : 0).
- Keys (RUN only): key period counter 0..KEY_PERIOD-1; at count 0 key[idx] driven 0 for exactly KEY_PULSE cycles, all others 1; then idx <= idx+1, wraps KEY_WIDTH-1 -> 0. At most one key low at any time.
- dut_resetn never glitches: registered output only.
- Async reset mid-operation returns to HOLD with all reset values; the full RESET_HOLD sequence replays.

Test Plan:
- Reset release: resetn 0->1 at cycle 0, enable=1 -> dut_resetn low cycles 0-4, high from cycle 5; sw=0x2AA throughout HOLD.
- Toggle mode, defaults: first sw_strobe 20 cycles into RUN, sw 0x2AA->0x155->0x2AA, strobes exactly 20 cycles apart, cycle_count=40 at second strobe.
- Increment wrap: SW_INIT=0x3FE, mode=1, SW_PERIOD=1 -> sw 0x3FE, 0x3FF, 0x000, 0x001; mode=2 from 0x200 -> 0x001; mode=3 from 0x001 -> 0x240, from 0 -> 0x001.
- Keys: defaults -> key=4'b1110 for 4 cycles, all 1s 60 cycles, then 4'b1101, 4'b1011, 4'b0111, back to 4'b1110; never two keys low.
- Pause/step: enable=0 mid key pulse -> key=4'b1111 next cycle, sw and cycle_count frozen; three step pulses in toggle mode -> three strobes, sw ends at ~value; enable=1 -> next strobe after the remaining frozen period count.
- Mid-run reset: assert resetn=0 during RUN -> immediately dut_resetn=0, sw=0x2AA, key=4'b1111, cycle_count=0; release -> 5-cycle HOLD repeats.
